// File: rtl/mouse_pkg.sv
// Shared encodings for the PS/2 mouse init/stream controller:
// FSM state values plus the command bytes sent and response bytes expected.
package mouse_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SEND_RST     = 3'd1,
    WAIT_ACK_RST = 3'd2,
    WAIT_BAT     = 3'd3,
    WAIT_ID      = 3'd4,
    SEND_EN      = 3'd5,
    WAIT_ACK_EN  = 3'd6,
    STREAM       = 3'd7
  } state_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

endpackage

// File: rtl/mouse_pkt_asm.sv
// Assembles 3-byte PS/2 stream packets into movement/button outputs.
// Optional build macro MOUSE_OVF_DROP_EN: packets flagging X/Y overflow are
// consumed silently instead of being delivered.
module mouse_pkt_asm (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] button,
  output logic       mouse_done
);

  logic [1:0] cnt;
  logic [7:0] b0, b1;
  logic       deliver;

`ifdef MOUSE_OVF_DROP_EN
  assign deliver = ~(b0[6] | b0[7]);
`else
  assign deliver = 1'b1;
`endif

  // Byte counter with resync on byte 0 (bit3 must be set), registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= 2'd0;
      b0         <= 8'h00;
      b1         <= 8'h00;
      xm         <= 9'd0;
      ym         <= 9'd0;
      button     <= 3'd0;
      mouse_done <= 1'b0;
    end else begin
      mouse_done <= 1'b0;
      if (clr) begin
        cnt <= 2'd0;
      end else if (en && rx_done) begin
        case (cnt)
          2'd0: if (rx_data[3]) begin
            b0  <= rx_data;
            cnt <= 2'd1;
          end
          2'd1: begin
            b1  <= rx_data;
            cnt <= 2'd2;
          end
          default: begin
            cnt <= 2'd0;
            if (deliver) begin
              xm         <= {b0[4], b1};
              ym         <= {b0[5], rx_data};
              button     <= b0[2:0];
              mouse_done <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mouse_seq_ctrl.sv
// PS/2 mouse init sequencer (reset, BAT, ID, enable) with timeout/retry,
// followed by stream-mode packet assembly.
// Optional build macro MOUSE_OVF_DROP_EN (applied inside mouse_pkt_asm).
module mouse_seq_ctrl
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_init,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] button,
  output logic       mouse_done,
  output logic       init_ok,
  output logic       init_err,
  output logic [2:0] state_reg
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t        state, next;
  logic          enter, fail, first, counting, tmo;
  logic [TW-1:0] tmr;
  logic [RW-1:0] retry;

  assign counting  = (state != IDLE) && (state != STREAM);
  assign tmo       = counting && (tmr == TW'(TIMEOUT_CYC - 1));
  assign tx_start  = first && ((state == SEND_RST) || (state == SEND_EN));
  assign state_reg = state;

  // Command byte is a pure function of the SEND state, so it holds until exit
  always_comb begin
    tx_data = 8'h00;
    if (state == SEND_RST) tx_data = CMD_RESET;
    else if (state == SEND_EN) tx_data = CMD_ENABLE;
  end

  // Next-state logic; enter flags any (re)entry, including SEND_RST -> SEND_RST
  always_comb begin
    next  = state;
    enter = 1'b0;
    fail  = 1'b0;
    if (start_init) begin
      next  = SEND_RST;
      enter = 1'b1;
    end else begin
      case (state)
        SEND_RST:     if (tx_done) next = WAIT_ACK_RST; else if (tmo) fail = 1'b1;
        SEND_EN:      if (tx_done) next = WAIT_ACK_EN;  else if (tmo) fail = 1'b1;
        WAIT_ACK_RST: if (rx_done) begin
                        if (rx_data == RSP_ACK) next = WAIT_BAT; else fail = 1'b1;
                      end else if (tmo) fail = 1'b1;
        WAIT_BAT:     if (rx_done) begin
                        if (rx_data == RSP_BAT_OK) next = WAIT_ID; else fail = 1'b1;
                      end else if (tmo) fail = 1'b1;
        WAIT_ID:      if (rx_done) begin
                        if (rx_data == RSP_ID) next = SEND_EN; else fail = 1'b1;
                      end else if (tmo) fail = 1'b1;
        WAIT_ACK_EN:  if (rx_done) begin
                        if (rx_data == RSP_ACK) next = STREAM; else fail = 1'b1;
                      end else if (tmo) fail = 1'b1;
        default: ;
      endcase
      if (fail) next = ((int'(retry) + 1) < MAX_RETRY) ? SEND_RST : IDLE;
      if (fail || (next != state)) enter = 1'b1;
    end
  end

  // State, first-cycle flag, timeout timer, retry count and sticky status
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      first    <= 1'b0;
      tmr      <= '0;
      retry    <= '0;
      init_ok  <= 1'b0;
      init_err <= 1'b0;
    end else begin
      state <= next;
      first <= enter;
      if (enter)         tmr <= '0;
      else if (counting) tmr <= tmr + 1'b1;
      if (start_init) begin
        retry    <= '0;
        init_ok  <= 1'b0;
        init_err <= 1'b0;
      end else begin
        if (fail) begin
          retry <= retry + 1'b1;
          if (next == IDLE) init_err <= 1'b1;
        end
        if (enter && (next == STREAM)) init_ok <= 1'b1;
      end
    end
  end

  mouse_pkt_asm u_pkt (
    .clk        (clk),
    .reset      (reset),
    .clr        (start_init),
    .en         (state == STREAM),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .xm         (xm),
    .ym         (ym),
    .button     (button),
    .mouse_done (mouse_done)
  );

endmodule

// File: tb/tb_mouse_seq_ctrl.sv
// Scoreboard bench for mouse_seq_ctrl: stimulus pushes expected tx bytes,
// packets and status snapshots; the monitor pops and compares on negedge.
module tb_mouse_seq_ctrl;
  import mouse_pkg::*;

  logic       clk = 1'b0, reset = 1'b0, start_init = 1'b0;
  logic       tx_done = 1'b0, rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_start, mouse_done, init_ok, init_err;
  logic [7:0] tx_data;
  logic [8:0] xm, ym;
  logic [2:0] button, state_reg;

  mouse_seq_ctrl #(.TIMEOUT_CYC(16), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset), .start_init(start_init),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .rx_done(rx_done), .rx_data(rx_data),
    .xm(xm), .ym(ym), .button(button), .mouse_done(mouse_done),
    .init_ok(init_ok), .init_err(init_err), .state_reg(state_reg)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] xm; logic [8:0] ym; logic [2:0] btn; } pkt_t;
  typedef struct {
    string nm; logic [2:0] st; logic ok; logic err; logic [7:0] txd;
    logic [8:0] xm; logic [8:0] ym; logic [2:0] btn;
  } st_t;

  logic [7:0] tx_q[$];
  pkt_t       pkt_q[$];
  st_t        st_q[$];
  int         errors = 0, checks = 0;
  bit         fin = 1'b0;
  logic [8:0] cur_xm = 9'd0, cur_ym = 9'd0;
  logic [2:0] cur_btn = 3'd0;

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic rx(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1; tick(); rx_done = 1'b0;
  endtask
  task automatic txd(); tx_done = 1'b1; tick(); tx_done = 1'b0; endtask
  task automatic exp_pkt(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
    pkt_t p; p.xm = x; p.ym = y; p.btn = b; pkt_q.push_back(p);
    cur_xm = x; cur_ym = y; cur_btn = b;
  endtask
  task automatic exp_st(input string nm, input logic [2:0] st, input logic ok,
                        input logic err, input logic [7:0] t);
    st_t s;
    s.nm = nm; s.st = st; s.ok = ok; s.err = err; s.txd = t;
    s.xm = cur_xm; s.ym = cur_ym; s.btn = cur_btn;
    st_q.push_back(s);
  endtask

  // Monitor: the only place comparisons are made and counted
  initial begin
    logic [7:0] e;
    pkt_t p;
    st_t  s;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        checks++;
        if (tx_q.size() == 0) begin
          errors++; $display("FAIL tx_start: unexpected pulse, tx_data=%h", tx_data);
        end else begin
          e = tx_q.pop_front();
          if (tx_data !== e) begin
            errors++; $display("FAIL tx_data: got %h expected %h", tx_data, e);
          end
        end
      end
      if (mouse_done) begin
        checks++;
        if (pkt_q.size() == 0) begin
          errors++; $display("FAIL mouse_done: unexpected pulse xm=%h ym=%h btn=%b", xm, ym, button);
        end else begin
          p = pkt_q.pop_front();
          if (xm !== p.xm || ym !== p.ym || button !== p.btn) begin
            errors++;
            $display("FAIL packet: got xm=%h ym=%h btn=%b expected xm=%h ym=%h btn=%b",
                     xm, ym, button, p.xm, p.ym, p.btn);
          end
        end
      end
      if (st_q.size() != 0) begin
        s = st_q.pop_front();
        checks++;
        if (state_reg !== s.st || init_ok !== s.ok || init_err !== s.err ||
            tx_data !== s.txd || xm !== s.xm || ym !== s.ym || button !== s.btn) begin
          errors++;
          $display("FAIL %s: got st=%0d ok=%b err=%b txd=%h xm=%h ym=%h btn=%b expected st=%0d ok=%b err=%b txd=%h xm=%h ym=%h btn=%b",
                   s.nm, state_reg, init_ok, init_err, tx_data, xm, ym, button,
                   s.st, s.ok, s.err, s.txd, s.xm, s.ym, s.btn);
        end
      end
      if (fin) begin
        checks++;
        if (tx_q.size() != 0 || pkt_q.size() != 0) begin
          errors++;
          $display("FAIL drain: got %0d tx and %0d packets outstanding, expected 0 and 0",
                   tx_q.size(), pkt_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    tick(); tick();
    exp_st("reset_state", 3'd0, 1'b0, 1'b0, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    exp_st("idle_after_reset", 3'd0, 1'b0, 1'b0, 8'h00);

    // Full init handshake
    tx_q.push_back(8'hFF);
    start_init = 1'b1; tick(); start_init = 1'b0;
    exp_st("send_rst", 3'd1, 1'b0, 1'b0, 8'hFF);
    txd();
    rx(8'hFA); rx(8'hAA);
    tx_q.push_back(8'hF4);
    rx(8'h00);
    exp_st("send_en", 3'd5, 1'b0, 1'b0, 8'hF4);
    txd();
    rx(8'hFA);
    exp_st("stream_ok", 3'd7, 1'b1, 1'b0, 8'h00);
    tick();

    // Packets
    exp_pkt(9'h105, 9'h0FE, 3'b001);
    rx(8'h19); rx(8'h05); rx(8'hFE);
    tick(); exp_st("hold_pkt1", 3'd7, 1'b1, 1'b0, 8'h00); tick();
    exp_pkt(9'h001, 9'h002, 3'b000);
    rx(8'h00); rx(8'h08); rx(8'h01); rx(8'h02);
    tick(); exp_st("hold_pkt2", 3'd7, 1'b1, 1'b0, 8'h00); tick();
`ifndef MOUSE_OVF_DROP_EN
    exp_pkt(9'h010, 9'h010, 3'b000);
`endif
    rx(8'h48); rx(8'h10); rx(8'h10);
    tick(); exp_st("ovf_pkt", 3'd7, 1'b1, 1'b0, 8'h00); tick();

    // Bad ACK retries, start_init mid-WAIT_BAT restarts
    tx_q.push_back(8'hFF);
    start_init = 1'b1; tick(); start_init = 1'b0;
    exp_st("reinit_clears_ok", 3'd1, 1'b0, 1'b0, 8'hFF);
    txd();
    tx_q.push_back(8'hFF);
    rx(8'hFE);
    exp_st("bad_ack_retry", 3'd1, 1'b0, 1'b0, 8'hFF);
    txd();
    rx(8'hFA);
    exp_st("wait_bat", 3'd3, 1'b0, 1'b0, 8'h00);
    tick();
    tx_q.push_back(8'hFF);
    start_init = 1'b1; tick(); start_init = 1'b0;
    exp_st("restart_mid_bat", 3'd1, 1'b0, 1'b0, 8'hFF);

    // Silent device: three timed-out attempts then init_err
    tx_q.push_back(8'hFF); tx_q.push_back(8'hFF);
    for (int i = 0; i < 200 && !init_err; i++) tick();
    exp_st("timeout_err", 3'd0, 1'b0, 1'b1, 8'h00);
    tick(); tick();
    exp_st("err_sticky", 3'd0, 1'b0, 1'b1, 8'h00);
    tick();

    // Reset mid-transaction, and reset beats start_init
    tx_q.push_back(8'hFF);
    start_init = 1'b1; tick(); start_init = 1'b0;
    txd();
    reset = 1'b0; start_init = 1'b1; tick(); start_init = 1'b0;
    cur_xm = 9'd0; cur_ym = 9'd0; cur_btn = 3'd0;
    exp_st("reset_mid_txn", 3'd0, 1'b0, 1'b0, 8'h00);
    tick(); reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    exp_st("quiet_after_reset", 3'd0, 1'b0, 1'b0, 8'h00);
    tick(); tick();
    fin = 1'b1;
  end

endmodule
